// File: rtl/islip_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | islip_scheduler_pkg                                                  |
// | Shared constants, FSM encoding and flat-index helper for iSLIP.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package islip_scheduler_pkg;

  localparam int PORT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_ISSUE  = 2'd3
  } state_e;

  function automatic int ptr_bits(input int port);
    return $clog2(port);
  endfunction

  // Position of (row, col) in a flattened [row*port + col] matrix.
  function automatic int flat_idx(input int row, input int col, input int port);
    return row * port + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/islip_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | islip_scheduler_if                                                   |
// | Request/issue bundle between VOQ banks, crossbar and the scheduler.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface islip_scheduler_if
  import islip_scheduler_pkg::*;
#(
  parameter int PORT = PORT_DEF
);
  localparam int PTR_BITS = ptr_bits(PORT);

  logic                   i_slot_start;
  logic [PORT*PORT-1:0]   i_req;
  logic                   o_busy;
  logic [PORT-1:0]        o_rd;
  logic [PORT*PORT-1:0]   o_rd_port;
  logic [PORT*PORT-1:0]   o_xbar_sel;
  logic [PTR_BITS:0]      o_match_cnt;

  modport master (
    output i_slot_start, i_req,
    input  o_busy, o_rd, o_rd_port, o_xbar_sel, o_match_cnt
  );

  modport slave (
    input  i_slot_start, i_req,
    output o_busy, o_rd, o_rd_port, o_xbar_sel, o_match_cnt
  );
endinterface
`default_nettype wire

// File: rtl/islip_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin selector: first request at or after ptr.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int PORT     = 8,
  parameter int PTR_BITS = $clog2(PORT)
) (
  input  logic [PORT-1:0]     i_req,
  input  logic [PTR_BITS-1:0] i_ptr,
  output logic [PORT-1:0]     o_gnt
);

  logic                w_found;
  logic [PTR_BITS-1:0] w_idx;

  // PORT is a power of two, so the pointer sum wraps naturally.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < PORT; k++) begin
      w_idx = i_ptr + PTR_BITS'(k);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/islip_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | islip_scheduler                                                      |
// | Single-iteration iSLIP matcher: GRANT, ACCEPT, ISSUE per slot pulse. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module islip_scheduler
  import islip_scheduler_pkg::*;
#(
  parameter int PORT = PORT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  islip_scheduler_if.slave   bus
);

  localparam int PTR_BITS = ptr_bits(PORT);

  state_e                 r_state, w_next;
  logic [PORT*PORT-1:0]   r_req;
  logic [PORT-1:0]        r_grant  [PORT];
  logic [PORT-1:0]        r_accept [PORT];
  logic [PTR_BITS-1:0]    r_g      [PORT];
  logic [PTR_BITS-1:0]    r_a      [PORT];
  logic [PORT*PORT-1:0]   r_xbar;
  logic [PTR_BITS:0]      r_cnt;

  logic [PORT-1:0]        w_gnt_req [PORT];
  logic [PORT-1:0]        w_gnt     [PORT];
  logic [PORT-1:0]        w_acc_req [PORT];
  logic [PORT-1:0]        w_acc     [PORT];
  logic [PTR_BITS-1:0]    w_g_nxt   [PORT];
  logic [PTR_BITS-1:0]    w_a_nxt   [PORT];
  logic [PORT*PORT-1:0]   w_xbar_nxt;
  logic [PTR_BITS:0]      w_cnt_nxt;

  // w_gnt_req[j] lists inputs asking for output j; w_acc_req[i] lists outputs granting input i.
  always_comb begin
    for (int k = 0; k < PORT; k++) begin
      w_gnt_req[k] = '0;
      w_acc_req[k] = '0;
    end
    for (int i = 0; i < PORT; i++) begin
      for (int j = 0; j < PORT; j++) begin
        w_gnt_req[j][i] = r_req[flat_idx(i, j, PORT)];
        w_acc_req[i][j] = r_grant[j][i];
      end
    end
  end

  generate
    for (genvar k = 0; k < PORT; k++) begin : g_arb
      rr_arbiter #(.PORT(PORT), .PTR_BITS(PTR_BITS)) u_grant (
        .i_req (w_gnt_req[k]),
        .i_ptr (r_g[k]),
        .o_gnt (w_gnt[k])
      );
      rr_arbiter #(.PORT(PORT), .PTR_BITS(PTR_BITS)) u_accept (
        .i_req (w_acc_req[k]),
        .i_ptr (r_a[k]),
        .o_gnt (w_acc[k])
      );
    end
  endgenerate

  // Each output grants one input, so each g[j] has at most one accepted writer.
  always_comb begin
    for (int k = 0; k < PORT; k++) begin
      w_g_nxt[k] = r_g[k];
      w_a_nxt[k] = r_a[k];
    end
    w_xbar_nxt = '0;
    w_cnt_nxt  = '0;
    for (int i = 0; i < PORT; i++) begin
      for (int j = 0; j < PORT; j++) begin
        if (w_acc[i][j]) begin
          w_a_nxt[i] = PTR_BITS'((j + 1) % PORT);
          w_g_nxt[j] = PTR_BITS'((i + 1) % PORT);
          w_xbar_nxt[flat_idx(j, i, PORT)] = 1'b1;
          w_cnt_nxt = w_cnt_nxt + (PTR_BITS+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.o_busy     = (r_state != ST_IDLE);
    bus.o_rd       = '0;
    bus.o_rd_port  = '0;
    case (r_state)
      ST_IDLE:   if (bus.i_slot_start) w_next = ST_GRANT;
      ST_GRANT:  w_next = ST_ACCEPT;
      ST_ACCEPT: w_next = ST_ISSUE;
      ST_ISSUE: begin
        w_next = ST_IDLE;
        for (int i = 0; i < PORT; i++) begin
          bus.o_rd[i]                  = |r_accept[i];
          bus.o_rd_port[i*PORT +: PORT] = r_accept[i];
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req  <= '0;
      r_xbar <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < PORT; k++) begin
        r_grant[k]  <= '0;
        r_accept[k] <= '0;
        r_g[k]      <= '0;
        r_a[k]      <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_slot_start) r_req <= bus.i_req;
        end
        ST_GRANT: begin
          for (int k = 0; k < PORT; k++) r_grant[k] <= w_gnt[k];
        end
        ST_ACCEPT: begin
          for (int k = 0; k < PORT; k++) begin
            r_accept[k] <= w_acc[k];
            r_g[k]      <= w_g_nxt[k];
            r_a[k]      <= w_a_nxt[k];
          end
          r_xbar <= w_xbar_nxt;
          r_cnt  <= w_cnt_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_xbar_sel  = r_xbar;
  assign bus.o_match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_islip_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_islip_scheduler                                                   |
// | Directed rounds checked against a matching model and literal values. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_islip_scheduler;

  localparam int P = 4;
  localparam int N = P * P;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  islip_scheduler_if #(.PORT(P)) bif ();

  islip_scheduler #(.PORT(P)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-level model: phase counts cycles of a round, match resolved as a whole.
  int           m_phase = 0;
  logic [N-1:0] m_snap  = '0;
  int           g [P]   = '{default: 0};
  int           a [P]   = '{default: 0};
  logic [P-1:0] m_rd    = '0;
  logic [N-1:0] m_port  = '0;
  logic [N-1:0] m_xbar  = '0;
  logic [2:0]   m_cnt   = '0;
  int           gr [P];
  int           acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_snap  = '0;
      m_rd    = '0;
      m_port  = '0;
      m_xbar  = '0;
      m_cnt   = '0;
      for (int k = 0; k < P; k++) begin g[k] = 0; a[k] = 0; end
    end else begin
      case (m_phase)
        0: if (bif.i_slot_start) begin m_snap = bif.i_req; m_phase = 1; end
        1: m_phase = 2;
        2: begin
          m_rd = '0; m_port = '0; m_xbar = '0; m_cnt = '0;
          for (int j = 0; j < P; j++) begin
            gr[j] = -1;
            for (int k = 0; k < P; k++)
              if (gr[j] < 0 && m_snap[((g[j] + k) % P) * P + j]) gr[j] = (g[j] + k) % P;
          end
          for (int i = 0; i < P; i++) begin
            acc = -1;
            for (int k = 0; k < P; k++)
              if (acc < 0 && gr[(a[i] + k) % P] == i) acc = (a[i] + k) % P;
            if (acc >= 0) begin
              m_rd[i]              = 1'b1;
              m_port[i * P + acc]  = 1'b1;
              m_xbar[acc * P + i]  = 1'b1;
              m_cnt                = m_cnt + 3'd1;
              a[i]                 = (acc + 1) % P;
              g[acc]               = (i + 1) % P;
            end
          end
          m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy",    64'(bif.o_busy),      64'(m_phase != 0));
    chk("rd",      64'(bif.o_rd),        64'((m_phase == 3) ? m_rd : 4'b0));
    chk("rd_port", 64'(bif.o_rd_port),   64'((m_phase == 3) ? m_port : 16'b0));
    chk("xbar",    64'(bif.o_xbar_sel),  64'(m_xbar));
    chk("cnt",     64'(bif.o_match_cnt), 64'(m_cnt));
    for (int j = 0; j < P; j++)
      chk("xbar_onehot", 64'($countones(bif.o_xbar_sel[j*P +: P]) <= 1), 64'd1);
  end

  task automatic round(input logic [N-1:0] req, input logic [3:0] e_rd,
                       input logic [N-1:0] e_port, input logic [N-1:0] e_xbar,
                       input logic [2:0] e_cnt, input bit extra_pulse);
    @(negedge clk);
    bif.i_req        = req;
    bif.i_slot_start = 1'b1;
    @(negedge clk);
    bif.i_slot_start = extra_pulse;
    bif.i_req        = ~req;
    chk("lit_busy_c1", 64'(bif.o_busy), 64'd1);
    @(negedge clk);
    bif.i_slot_start = 1'b0;
    chk("lit_busy_c2", 64'(bif.o_busy), 64'd1);
    chk("lit_rd_c2",   64'(bif.o_rd),   64'd0);
    @(negedge clk);
    chk("lit_busy_c3", 64'(bif.o_busy),      64'd1);
    chk("lit_rd",      64'(bif.o_rd),        64'(e_rd));
    chk("lit_rd_port", 64'(bif.o_rd_port),   64'(e_port));
    chk("lit_xbar",    64'(bif.o_xbar_sel),  64'(e_xbar));
    chk("lit_cnt",     64'(bif.o_match_cnt), 64'(e_cnt));
    @(negedge clk);
    chk("lit_busy_c4", 64'(bif.o_busy), 64'd0);
    chk("lit_rd_c4",   64'(bif.o_rd),   64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bif.i_slot_start = 1'b0;
    bif.i_req        = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bif.o_busy),      64'd0);
    chk("rst_rd",   64'(bif.o_rd),        64'd0);
    chk("rst_xbar", 64'(bif.o_xbar_sel),  64'd0);
    chk("rst_cnt",  64'(bif.o_match_cnt), 64'd0);
    rst_n = 1'b1;

    round(16'hFFFF, 4'b0001, 16'h0001, 16'h0001, 3'd1, 1'b0);
    round(16'hFFFF, 4'b0011, 16'h0012, 16'h0012, 3'd2, 1'b0);
    round(16'hFFFF, 4'b0111, 16'h0124, 16'h0124, 3'd3, 1'b0);

    do_reset();
    round(16'h0023, 4'b0001, 16'h0001, 16'h0001, 3'd1, 1'b0);
    round(16'h0023, 4'b0001, 16'h0002, 16'h0010, 3'd1, 1'b0);
    round(16'h0000, 4'b0000, 16'h0000, 16'h0000, 3'd0, 1'b0);
    round(16'h0023, 4'b0011, 16'h0021, 16'h0021, 3'd2, 1'b0);

    round(16'h8000, 4'b1000, 16'h8000, 16'h8000, 3'd1, 1'b0);
    round(16'h8008, 4'b0001, 16'h0008, 16'h1000, 3'd1, 1'b0);

    round(16'hFFFF, 4'b0111, 16'h0284, 16'h2140, 3'd3, 1'b1);

    @(negedge clk);
    bif.i_req        = 16'hFFFF;
    bif.i_slot_start = 1'b1;
    @(negedge clk);
    bif.i_slot_start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bif.o_busy),      64'd0);
    chk("abort_rd",   64'(bif.o_rd),        64'd0);
    chk("abort_xbar", 64'(bif.o_xbar_sel),  64'd0);
    chk("abort_cnt",  64'(bif.o_match_cnt), 64'd0);
    @(negedge clk);
    chk("abort_rd_c3", 64'(bif.o_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    round(16'hFFFF, 4'b0001, 16'h0001, 16'h0001, 3'd1, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/islip_scheduler.md
Name: islip_scheduler

Overview:
- Single-iteration iSLIP match scheduler for a PORT x PORT input-queued crossbar.
- Consumes the per-destination request vectors from PORT input-side VOQ banks.
- Returns to each bank a one-cycle read strobe plus a one-hot destination port, and gives the crossbar a per-output one-hot input select.
- Runs one scheduling round per cell slot, started by a slot pulse; round-robin grant and accept pointers move only on accepted matches.

Parameters:
- PORT, 8, number of switch inputs and outputs (power of two, 2..16).
- PTR_BITS, clog2(PORT), width of each round-robin pointer; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_slot_start  input  1  single-cycle pulse that starts one scheduling round.
- i_req  input  PORT*PORT  bit [i*PORT+j] set when input i's VOQ for output j is non-empty.
- o_busy  output  1  high while a round is in progress (GRANT, ACCEPT, ISSUE).
- o_rd  output  PORT  bit i is the read strobe to VOQ bank i; high for exactly one cycle, in ISSUE.
- o_rd_port  output  PORT*PORT  field [i*PORT +: PORT] is a one-hot output port for bank i; valid when o_rd[i]=1, zero otherwise.
- o_xbar_sel  output  PORT*PORT  field [j*PORT +: PORT] is a one-hot input feeding output j; held until the next ISSUE.
- o_match_cnt  output  PTR_BITS+1  number of matches made in the last round; held.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state = IDLE;
  - all grant pointers g[j] = 0 and all accept pointers a[i] = 0;
  - all outputs = 0.
  - Asserting reset mid-round aborts the round; no o_rd pulse is issued for it.
- FSM states: IDLE -> GRANT -> ACCEPT -> ISSUE -> IDLE.
  - IDLE: on i_slot_start=1, register the i_req snapshot and go to GRANT.
  - i_slot_start is ignored in every non-IDLE state.
- GRANT:
  - For each output j, pick the first requesting input at or after g[j], searching round-robin upward with wrap from PORT-1 to 0.
  - Register the grant matrix; an output with no requester grants nothing.
- ACCEPT:
  - For each input i, pick the first granting output at or after a[i], round-robin.
  - Register the accept matrix.
  - For each accepted pair (i,j), update a[i] <= (j+1) mod PORT and g[j] <= (i+1) mod PORT in the same edge.
  - Pointers of outputs whose grant was refused, and of unmatched inputs, are unchanged.
- ISSUE (one cycle):
  - o_rd[i] = 1 and o_rd_port field i = accepted output, for each matched input.
  - o_xbar_sel and o_match_cnt update on entry to ISSUE.
  - Next state is IDLE.
- Latency: i_slot_start at cycle 0 -> o_rd valid at cycle 3; minimum slot period is 4 cycles.
- Matching invariants:
  - at most one bit set per o_rd_port field;
  - at most one bit set per o_xbar_sel field;
  - no output is matched to two inputs.
- Empty requests give o_rd = 0, o_match_cnt = 0, and pointers unchanged.
- Pointer wrap: a match with i = PORT-1 sets g[j] = 0.
- i_req changes after the snapshot have no effect on the current round.

Decomposition:
- Shared package: PORT default, PTR_BITS derivation, FSM state encoding constants, and index helpers for the flattened [i*PORT+j] layout.
- One natural sub-module: rr_arbiter.
  - Combinational PORT-wide round-robin priority selector.
  - Inputs: request vector, PTR_BITS start pointer. Output: one-hot grant.
  - Instantiated PORT times for the grant stage and PORT times for the accept stage.

Test Plan (PORT=4):
1. Reset, i_req = all ones, three consecutive rounds -> match counts 1, 2, 3.
   - Round 1: in0->out0.
   - Round 2: in0->out1, in1->out0.
   - Round 3: in0->out2, in1->out1, in2->out0.
2. i_req: in0 requests {out0,out1}, in1 requests {out1} -> round 1 matches only in0->out0 and g[1] stays 0. Round 2 with the same requests matches in0->out1; afterwards g[1] = 1 and a[0] = 2.
3. i_req = 0, slot pulse -> o_busy high for 3 cycles, o_rd = 0, o_match_cnt = 0, pointers unchanged.
4. Only in3->out3 requested -> o_rd = 4'b1000, o_rd_port field 3 = 4'b1000, o_xbar_sel field 3 = 4'b1000; afterwards g[3] = 0 and a[3] = 0 (wrap).
5. i_slot_start pulsed again in GRANT -> ignored; exactly one o_rd pulse at cycle 3.
6. reset driven low during ACCEPT -> outputs 0 immediately; no o_rd pulse; next round after release behaves as from power-up (round 1 of scenario 1).
